// File: rtl/sort_pkg.sv
// sort_pkg: shared state type, parameter defaults and helpers for the sort-engine arbiter
package sort_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SORT, DRAIN, RELEASE} state_t;
  localparam int DW_DEF = 32;
  localparam int COUNT_DEF = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first set request at or after ptr, with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin : search
    logic found;
    logic [IW-1:0] j;
    onehot = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        onehot[j] = 1'b1;
        idx = j;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/sort_job_arbiter.sv
// sort_job_arbiter: round-robin sharing of one sort engine; load, sort with watchdog, drain tagged words
module sort_job_arbiter
  import sort_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = DW_DEF,
  parameter int COUNT        = COUNT_DEF,
  parameter int SORT_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     req_data,
  input  logic [NREQ-1:0]        req_wvalid,
  output logic [NREQ-1:0]        grant,
  output logic                   wready,
  output logic                   s_in_valid,
  output logic [DW-1:0]          s_in_data,
  input  logic                   s_out_valid,
  input  logic [DW-1:0]          s_out_data,
  output logic                   s_clr,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [clog2(NREQ)-1:0] out_id,
  output logic                   out_last,
  output logic                   err,
  output logic                   busy
);
  localparam int IW = clog2(NREQ);
  localparam int TW = clog2(SORT_TIMEOUT + 1);
  state_t state, state_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0] pick_idx, owner, rr_ptr;
  logic pick_valid, xfer, sorting, word, last, abort, armed, clr_init;
  logic [7:0] load_cnt, drain_cnt;
  logic [TW-1:0] timer;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign xfer = state == LOAD && req_wvalid[owner];
  assign sorting = state == SORT || state == DRAIN;
  assign word = sorting && s_out_valid;
  assign last = word && drain_cnt == 8'(COUNT - 1);
  // a word landing on the timeout cycle wins, so abort only fires on a silent cycle
  assign abort = sorting && !s_out_valid && timer == TW'(SORT_TIMEOUT);
  assign wready = state == LOAD;
  assign s_in_valid = xfer;
  assign s_in_data = xfer ? req_data[owner*DW +: DW] : '0;
  assign out_valid = word;
  assign out_data = word ? s_out_data : '0;
  assign out_id = word ? owner : '0;
  assign out_last = last;
  assign err = abort;
  assign s_clr = abort || clr_init;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = pick_valid ? LOAD : IDLE;
      LOAD:    state_d = xfer && load_cnt == 8'(COUNT - 1) ? SORT : LOAD;
      SORT:    state_d = last || abort ? RELEASE : word ? DRAIN : SORT;
      DRAIN:   state_d = last || abort ? RELEASE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= '0;
      owner <= '0;
      rr_ptr <= '0;
      load_cnt <= '0;
      drain_cnt <= '0;
      timer <= '0;
      armed <= 1'b0;
      clr_init <= 1'b0;
    end else begin
      armed <= 1'b1;
      clr_init <= !armed;
      if (state == IDLE && pick_valid) begin
        grant <= pick_oh;
        owner <= pick_idx;
      end
      if (state == RELEASE) begin
        grant <= '0;
        rr_ptr <= owner == IW'(NREQ - 1) ? '0 : owner + 1'b1;
      end
      load_cnt <= state == RELEASE ? '0 : load_cnt + {7'd0, xfer};
      drain_cnt <= state == RELEASE ? '0 : drain_cnt + {7'd0, word};
      timer <= !sorting || word ? '0 : timer + {{(TW-1){1'b0}}, timer != TW'(SORT_TIMEOUT)};
    end
  end
endmodule

// File: tb/tb_sort_job_arbiter.sv
// tb_sort_job_arbiter: directed job sequence with random data, checked against a queue-based sort/arbitration model
module tb_sort_job_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 32;
  localparam int COUNT = 8;
  localparam int TO = 100;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] req_wvalid = '0;
  logic s_out_valid = 1'b0;
  logic [DW-1:0] s_out_data = '0;
  logic [NREQ-1:0] grant;
  logic wready, s_in_valid, s_clr, out_valid, out_last, err, busy;
  logic [DW-1:0] s_in_data, out_data;
  logic [IW-1:0] out_id;
  int tests = 0;
  int fails = 0;
  int mptr = 0;
  int pulses;
  logic [DW-1:0] fixed_q[$];
  always #5 clk = ~clk;
  sort_job_arbiter #(.NREQ(NREQ), .DW(DW), .COUNT(COUNT), .SORT_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .req_wvalid(req_wvalid),
    .grant(grant),
    .wready(wready),
    .s_in_valid(s_in_valid),
    .s_in_data(s_in_data),
    .s_out_valid(s_out_valid),
    .s_out_data(s_out_data),
    .s_clr(s_clr),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .out_last(out_last),
    .err(err),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic posc();
    @(posedge clk);
    #1;
  endtask
  task automatic negc();
    @(negedge clk);
  endtask
  function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_s_in_valid"}, s_in_valid, 0);
    chk({tag, "_s_in_data"}, s_in_data, 0);
    chk({tag, "_s_clr"}, s_clr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic finish_job(input int w, input logic [NREQ-1:0] rel_clr);
    req = req & ~rel_clr;
    negc();
    chk("release_busy", busy, 1);
    chk("release_quiet", out_valid, 0);
    posc();
    negc();
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    posc();
    mptr = (w + 1) % NREQ;
  endtask
  task automatic run_job(input bit use_fixed, input bit respond, input int last_gap,
                         input int mid_at, input logic [NREQ-1:0] mid_set,
                         input logic [NREQ-1:0] mid_clr, input logic [NREQ-1:0] rel_clr,
                         input int rst_at);
    int w, cyc, gap;
    logic [NREQ-1:0] own;
    logic [DW-1:0] d;
    logic [DW-1:0] words[$];
    logic [DW-1:0] sorted[$];
    w = rr_model(req, mptr);
    own = NREQ'(1) << w;
    cyc = 0;
    while (grant == '0 && cyc < 10) begin
      posc();
      cyc++;
    end
    chk("grant", grant, own);
    for (int i = 0; i < COUNT; i++) begin
      d = use_fixed ? fixed_q[i] : $urandom;
      repeat ($urandom_range(0, 2)) begin
        req_wvalid = NREQ'($urandom) & ~own;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        s_out_valid = 1'($urandom);
        negc();
        chk("wready_stall", wready, 1);
        chk("stray_in", s_in_valid, 0);
        chk("stray_out_load", out_valid, 0);
        posc();
      end
      if (i == mid_at) req = (req | mid_set) & ~mid_clr;
      req_wvalid = (NREQ'($urandom) & ~own) | own;
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req_data[w*DW +: DW] = d;
      s_out_valid = 1'($urandom);
      negc();
      chk("in_valid", s_in_valid, 1);
      chk("in_data", s_in_data, d);
      chk("wready", wready, 1);
      chk("stray_out_load", out_valid, 0);
      words.push_back(d);
      posc();
    end
    req_wvalid = '0;
    s_out_valid = 1'b0;
    sorted = words;
    sorted.sort();
    if (!respond) begin
      for (int k = 0; k <= TO; k++) begin
        negc();
        if (k == 0) chk("wready_sort", wready, 0);
        chk("wd_err", err, k == TO);
        chk("wd_clr", s_clr, k == TO);
        chk("wd_no_out", out_valid, 0);
        posc();
      end
      finish_job(w, rel_clr);
      return;
    end
    negc();
    chk("wready_sort", wready, 0);
    chk("busy_sort", busy, 1);
    posc();
    repeat ($urandom_range(0, 4)) begin
      negc();
      chk("sort_quiet", out_valid, 0);
      chk("sort_no_err", err, 0);
      posc();
    end
    for (int i = 0; i < COUNT; i++) begin
      gap = (i == COUNT - 1 && last_gap >= 0) ? last_gap : (i == 0 ? 0 : $urandom_range(0, 2));
      repeat (gap) begin
        negc();
        chk("gap_quiet", out_valid, 0);
        chk("gap_no_err", err, 0);
        posc();
      end
      s_out_valid = 1'b1;
      s_out_data = sorted[i];
      if (i == rst_at) begin
        #1 chk("pre_reset_out", out_valid, 1);
        reset = 1'b0;
        #1 chk_zero("async_reset");
        s_out_valid = 1'b0;
        req = '0;
        mptr = 0;
        return;
      end
      negc();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, sorted[i]);
      chk("out_id", out_id, w[IW-1:0]);
      chk("out_last", out_last, i == COUNT - 1);
      chk("err_vs_word", err, 0);
      posc();
      s_out_valid = 1'b0;
    end
    finish_job(w, rel_clr);
  endtask
  initial begin
    repeat (3) posc();
    chk_zero("reset");
    reset = 1'b1;
    pulses = 0;
    repeat (3) begin
      negc();
      pulses += int'(s_clr);
      posc();
    end
    chk("s_clr_after_reset", pulses, 1);
    s_out_valid = 1'b1;
    repeat (3) begin
      s_out_data = $urandom;
      negc();
      chk("idle_stray_out", out_valid, 0);
      chk("idle_stray_busy", busy, 0);
      posc();
    end
    s_out_valid = 1'b0;
    fixed_q = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
    req = 4'b0001;
    run_job(1, 1, -1, -1, '0, '0, 4'b0001, -1);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) run_job(0, 1, -1, -1, '0, '0, j == 4 ? 4'b1111 : 4'b0000, -1);
    req = 4'b0001;
    run_job(0, 1, -1, 3, 4'b0100, 4'b0001, 4'b0000, -1);
    run_job(0, 1, TO, -1, '0, '0, 4'b0100, -1);
    req = 4'b0010;
    run_job(0, 0, -1, -1, '0, '0, 4'b0010, -1);
    req = 4'b1000;
    run_job(0, 1, -1, -1, '0, '0, '0, 3);
    repeat (2) posc();
    chk_zero("held_reset");
    reset = 1'b1;
    pulses = 0;
    repeat (3) begin
      negc();
      pulses += int'(s_clr);
      posc();
    end
    chk("s_clr_after_mid_reset", pulses, 1);
    req = 4'b1010;
    run_job(0, 1, -1, -1, '0, '0, 4'b1010, -1);
    repeat (4) begin
      req = NREQ'($urandom_range(1, 15));
      run_job(0, 1, -1, -1, '0, '0, 4'b1111, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sort_job_arbiter.md
Name: sort_job_arbiter

Overview:
- Shares one insertion-sort engine between NREQ requesters.
- Each job loads COUNT words from the granted requester, waits while the engine sorts, then drains COUNT sorted words back tagged with the owner's ID.
- Round-robin arbitration between jobs; a watchdog aborts a hung engine and clears it.
- Sits between the requester-side stream ports and the sort engine's word-in / word-out ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data word width.
- COUNT, 8, words per sort job (1..255).
- SORT_TIMEOUT, 1024, max cycles in SORT before abort (>=COUNT*COUNT+COUNT).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until that requester sees out_last.
- req_data  in  NREQ*DW  per-requester word, slice i = requester i.
- req_wvalid  in  NREQ  per-requester word valid.
- grant  out  NREQ  one-hot owner of the current job; zero when idle.
- wready  out  1  high in LOAD; a word transfers when wready & req_wvalid[owner].
- s_in_valid  out  1  word strobe to engine.
- s_in_data  out  DW  word to engine.
- s_out_valid  in  1  engine sorted-word strobe.
- s_out_data  in  DW  engine sorted word.
- s_clr  out  1  one-cycle engine clear pulse.
- out_valid  out  1  sorted word valid, broadcast to all requesters.
- out_data  out  DW  sorted word.
- out_id  out  clog2(NREQ)  owner index of out_data.
- out_last  out  1  with final word of a job.
- err  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_ptr=0; counters=0; all outputs 0. A reset mid-job discards the job. s_clr pulses once in the first cycle after reset release.
- IDLE:
  - If req!=0, grant the first set bit at or after rr_ptr, searching with wrap.
  - grant registers next cycle; go to LOAD.
  - No request: stay in IDLE.
- LOAD:
  - wready=1.
  - Each transfer drives s_in_valid=1 and s_in_data = owner slice in the same cycle (combinational pass-through, zero latency), and increments load_cnt.
  - When load_cnt reaches COUNT, go to SORT; wready drops that cycle.
  - Non-owner wvalid is ignored.
  - Owner dropping req is ignored; the job completes.
- SORT:
  - Timeout counter runs.
  - First s_out_valid goes to DRAIN and is forwarded in the same cycle.
  - Timer == SORT_TIMEOUT: err=1, s_clr=1, go to RELEASE with no output.
- DRAIN:
  - Each s_out_valid forwards to out_valid/out_data with out_id=owner; drain_cnt increments.
  - The COUNT-th word asserts out_last and goes to RELEASE.
  - No backpressure on the output side; requesters must accept.
  - s_out_valid outside SORT/DRAIN is dropped silently.
  - Watchdog also runs in DRAIN and restarts on each word.
- RELEASE (1 cycle):
  - grant=0; rr_ptr = owner+1 mod NREQ; counters clear; return to IDLE.
  - The next grant is therefore no earlier than 2 cycles after out_last.
- Fairness: a requester holding req continuously waits at most NREQ-1 jobs.
- Widths:
  - load_cnt and drain_cnt are 8-bit.
  - Timer is clog2(SORT_TIMEOUT+1) bits and saturates.
  - out_id is the binary encoding of one-hot grant.
- Simultaneous events:
  - req rising in the same cycle as RELEASE is seen in the following IDLE cycle.
  - Timeout and the final s_out_valid in the same cycle: the data word wins (out_last, no err).

Decomposition:
- Shared package sort_pkg holds:
  - state enum: IDLE, LOAD, SORT, DRAIN, RELEASE;
  - DW and COUNT defaults;
  - the clog2 function.
- One sub-module: rr_pick (combinational round-robin first-set-bit search from rr_ptr; outputs one-hot and index), reusable by other shared-resource arbiters.
- FSM, counters and watchdog stay in the top module.

Test Plan:
1. Single job: req=0001, requester 0 sends 5,3,8,1,9,2,7,4 → 8 s_in_valid pulses in order; engine model returns 1..9 set → out_id=0 on all 8 words; out_last on 9; grant=0 after RELEASE.
2. Round-robin: req=1111 held constant, four jobs → grant sequence 0001, 0010, 0100, 1000, then 0001 again; out_id matches each job.
3. Contention mid-job: requester 2 raises req while 0 is in LOAD, and requester 0 drops req mid-LOAD → job 0 still completes all 8 words; next grant=0100.
4. Watchdog: engine model never returns data, SORT_TIMEOUT=100 → err pulse exactly 100 cycles after SORT entry, s_clr pulse in the same cycle, no out_valid, busy low 2 cycles later.
5. Reset mid-DRAIN after 3 words → all outputs 0 immediately (async); s_clr pulse after release; the next req=0010 is granted with rr_ptr=0 (searches from 0, grants 1).
6. Stray traffic: req_wvalid from non-owners in LOAD and s_out_valid in IDLE → no s_in_valid from non-owners, no out_valid in IDLE.
